adder_arbiter: RTL

- Shares one registered WIDTH-bit adder between NUM_REQ requesters.
- Uses round-robin arbitration and a valid/ready handshake on each requester port.
- Returns each result on a single response channel tagged with the requester id.
- Sits between multiple stimulus sources (bus masters, test sequencers) and the shared adder datapath; the arbitration, sequencing and result holding are all done here.

---
 rtl/adder_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// ============================================================================
// Module   : adder_arbiter
// Brief    : Round-robin arbiter sharing one registered adder between NUM_REQ
//            requesters. Optional macro ADDER_ARB_SAT_EN saturates the sum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [WIDTH-1:0]           resp_sum,
   output logic                       resp_carry,
   output logic [$clog2(NUM_REQ)-1:0] resp_id,
   output logic                       busy
);

   localparam int ID_W = $clog2(NUM_REQ);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_calc = 2'd1;
   localparam logic [1:0] c_resp = 2'd2;

   logic [1:0]         r_state;
   logic [ID_W-1:0]    r_last_grant;
   logic [ID_W-1:0]    r_id;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic [ID_W-1:0]    r_resp_id;

   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]    w_grant_id;
   logic               w_found;
   int                 w_idx;
   logic [WIDTH:0]     w_sum_full;

   // Search upward from the requester after the last winner, wrapping once.
   always_comb begin
      w_grant    = '0;
      w_grant_id = '0;
      w_found    = 1'b0;
      w_idx      = 0;
      if (r_state == c_idle) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = int'(r_last_grant) + k;
            if (w_idx >= NUM_REQ) begin
               w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && req_valid[w_idx]) begin
               w_found         = 1'b1;
               w_grant[w_idx]  = 1'b1;
               w_grant_id      = ID_W'(w_idx);
            end
         end
      end
   end

   assign w_sum_full = {1'b0, r_a} + {1'b0, r_b};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= c_idle;
         // Pointing at the last requester makes requester 0 the first choice.
         r_last_grant <= ID_W'(NUM_REQ - 1);
         r_id         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_sum        <= '0;
         r_carry      <= 1'b0;
         r_resp_id    <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (w_found) begin
                  r_a          <= req_a[w_grant_id*WIDTH +: WIDTH];
                  r_b          <= req_b[w_grant_id*WIDTH +: WIDTH];
                  r_id         <= w_grant_id;
                  r_last_grant <= w_grant_id;
                  r_state      <= c_calc;
               end
            end
            c_calc: begin
               r_carry   <= w_sum_full[WIDTH];
               r_resp_id <= r_id;
`ifdef ADDER_ARB_SAT_EN
               r_sum     <= w_sum_full[WIDTH] ? '1 : w_sum_full[WIDTH-1:0];
`else
               r_sum     <= w_sum_full[WIDTH-1:0];
`endif
               r_state   <= c_resp;
            end
            c_resp: begin
               if (resp_ready) begin
                  r_state <= c_idle;
               end
            end
            default: r_state <= c_idle;
         endcase
      end
   end

   assign req_ready  = w_grant;
   assign resp_valid = (r_state == c_resp);
   assign resp_sum   = r_sum;
   assign resp_carry = r_carry;
   assign resp_id    = r_resp_id;
   assign busy       = (r_state != c_idle);

endmodule

`default_nettype wire
